// File: rtl/mono_pulse_timer_pkg.sv
// Shared types and constants for the mono_pulse_timer monostable engine.
package mono_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } state_t;

    // Inactive pin levels, used as synchronizer presets so reset looks like an idle socket
    localparam logic NA_IDLE = 1'b1;
    localparam logic B_IDLE  = 1'b0;
    localparam logic NR_IDLE = 1'b1;

    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/mono_pulse_timer_sync_ff.sv
// Single-bit multi-flop synchronizer with a configurable preset value.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p <= {STAGES{RST_VAL}};
        end else begin
            sync_p <= {sync_p[STAGES-2:0], d};
        end
    end

    assign q = sync_p[STAGES-1];

endmodule

// File: rtl/mono_pulse_timer.sv
// HC221-style monostable: synchronized nA/B/nR trigger, programmable Q width in clk cycles.
// Define MONO_RETRIGGER_EN for HC123-style retriggering (trigger during a pulse reloads the count).
module mono_pulse_timer
    import mono_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             nA_in,
    input  logic             B_in,
    input  logic             nR_in,
    input  logic [CNT_W-1:0] pulse_len,
    output logic             Q,
    output logic             nQ,
    output logic             done
);

    localparam int FILL_W = $clog2(SYNC_STAGES + 1);

    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
        return (len == '0) ? CNT_W'(1) : len;
    endfunction

    logic na_s;
    logic b_s;
    logic nr_s;

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(NA_IDLE)) u_sync_na (
        .clk (clk),
        .rst (rst),
        .d   (nA_in),
        .q   (na_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(B_IDLE)) u_sync_b (
        .clk (clk),
        .rst (rst),
        .d   (B_in),
        .q   (b_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(NR_IDLE)) u_sync_nr (
        .clk (clk),
        .rst (rst),
        .d   (nR_in),
        .q   (nr_s)
    );

    logic [FILL_W-1:0] fill_cnt;
    logic              primed;
    logic              trig_lvl;
    logic              trig_lvl_p1;
    logic              trig;
    logic              retrig;

    assign primed   = (fill_cnt == FILL_W'(SYNC_STAGES));
    assign trig_lvl = ~na_s & b_s & nr_s;
    assign trig     = trig_lvl & ~trig_lvl_p1;

    // Stage p1: until the sync chains hold real pin values, pretend the trigger level was
    // already active so a level held through reset cannot produce an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt    <= '0;
            trig_lvl_p1 <= 1'b0;
        end else begin
            if (!primed) begin
                fill_cnt <= fill_cnt + FILL_W'(1);
            end
            trig_lvl_p1 <= primed ? trig_lvl : 1'b1;
        end
    end

`ifdef MONO_RETRIGGER_EN
    assign retrig = trig;
`else
    assign retrig = 1'b0;
`endif

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;
    logic             done_r;
    logic             done_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            done_r <= done_n;
        end
    end

    // Clear outranks both a natural end and any trigger in the same cycle
    always_comb begin
        state_n = state;
        count_n = count;
        done_n  = 1'b0;
        if (!nr_s) begin
            state_n = IDLE;
            count_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig) begin
                        state_n = PULSE;
                        count_n = clamp_len(pulse_len);
                    end
                end
                PULSE: begin
                    if (retrig) begin
                        count_n = clamp_len(pulse_len);
                    end else if (count == CNT_W'(1)) begin
                        state_n = IDLE;
                        count_n = '0;
                        done_n  = 1'b1;
                    end else begin
                        count_n = count - CNT_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    count_n = '0;
                end
            endcase
        end
    end

    assign Q    = (state == PULSE);
    assign nQ   = ~Q;
    assign done = done_r;

endmodule

// File: tb/tb_mono_pulse_timer.sv
// Directed bench for mono_pulse_timer (SYNC_STAGES=2, CNT_W=16); honours MONO_RETRIGGER_EN.
module tb_mono_pulse_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        nA_in;
    logic        B_in;
    logic        nR_in;
    logic [15:0] pulse_len;
    logic        Q;
    logic        nQ;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;

`ifdef MONO_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    always #5 clk = ~clk;

    mono_pulse_timer #(.SYNC_STAGES(2), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .nA_in     (nA_in),
        .B_in      (B_in),
        .nR_in     (nR_in),
        .pulse_len (pulse_len),
        .Q         (Q),
        .nQ        (nQ),
        .done      (done)
    );

    // kind 0: one-cycle nA low pulse; 1: B rises; 2: nR rises. Pin driven at negedge t=0.
    // retrig_at/clr_at refer to the Q-high sample index (1-based); 0 disables.
    task automatic fire(input int kind, input int retrig_at, input int clr_at, input int swap_len,
                        output int lat, output int width, output int ndone, output logic done_fall,
                        output int rises, output int nq_err, output logic tmo);
        int   t;
        int   pc;
        int   after;
        logic prev_q;
        logic fell;
        lat = -1; width = 0; ndone = 0; done_fall = 1'b0; rises = 0; nq_err = 0;
        pc = 0; after = 0; prev_q = 1'b0; fell = 1'b0; t = 0;
        @(negedge clk);
        case (kind)
            0: nA_in = 1'b0;
            1: B_in  = 1'b1;
            default: nR_in = 1'b1;
        endcase
        while (after < 8 && t < 70000) begin
            @(negedge clk);
            t++;
            if (nQ !== ~Q) nq_err++;
            if (Q === 1'b1 && !prev_q) begin
                rises++;
                if (lat < 0) lat = t;
            end
            if (Q === 1'b1) begin
                width++;
                pc++;
            end
            if (done === 1'b1) ndone++;
            if (Q !== 1'b1 && prev_q && !fell) begin
                fell = 1'b1;
                done_fall = done;
            end
            if (fell) after++;
            prev_q = (Q === 1'b1);
            if (kind == 0) nA_in = (Q === 1'b1 && pc == retrig_at) ? 1'b0 : 1'b1;
            if (clr_at > 0 && pc >= clr_at) nR_in = 1'b0;
            if (swap_len >= 0 && pc == 2) pulse_len = swap_len[15:0];
        end
        tmo = (after < 8);
    endtask

    task automatic test_reset();
        int highs;
        int dones;
        rst = 1'b1; nA_in = 1'b1; B_in = 1'b0; nR_in = 1'b1; pulse_len = 16'd5;
        repeat (2) @(negedge clk);
        vectors++; if (Q !== 1'b0) begin miscompares++; $display("FAIL reset.q_in got %b want 0", Q); end
        vectors++; if (nQ !== 1'b1) begin miscompares++; $display("FAIL reset.nq_in got %b want 1", nQ); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset.done_in got %b want 0", done); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (Q !== 1'b0) begin miscompares++; $display("FAIL reset.q_after got %b want 0", Q); end
        vectors++; if (nQ !== 1'b1) begin miscompares++; $display("FAIL reset.nq_after got %b want 1", nQ); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset.done_after got %b want 0", done); end
        rst = 1'b1; nA_in = 1'b0; B_in = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        highs = 0; dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (Q !== 1'b0) highs++;
            if (done !== 1'b0) dones++;
        end
        vectors++; if (highs !== 0) begin miscompares++; $display("FAIL reset.held_level got %0d high cycles want 0", highs); end
        vectors++; if (dones !== 0) begin miscompares++; $display("FAIL reset.held_done got %0d want 0", dones); end
        nA_in = 1'b1; B_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, w, nd, r, nqe;
        logic df, tmo;
        nA_in = 1'b1; B_in = 1'b1; nR_in = 1'b1; pulse_len = 16'd5;
        repeat (4) @(negedge clk);
        vectors++; if (Q !== 1'b0) begin miscompares++; $display("FAIL basic.idle got %b want 0", Q); end
        fire(0, 0, 0, 2, lat, w, nd, df, r, nqe, tmo);
        vectors++; if (tmo !== 1'b0) begin miscompares++; $display("FAIL basic.timeout got %b want 0", tmo); end
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL basic.latency got %0d want 3", lat); end
        vectors++; if (w !== 5) begin miscompares++; $display("FAIL basic.width got %0d want 5", w); end
        vectors++; if (nd !== 1) begin miscompares++; $display("FAIL basic.done_count got %0d want 1", nd); end
        vectors++; if (df !== 1'b1) begin miscompares++; $display("FAIL basic.done_at_fall got %b want 1", df); end
        vectors++; if (r !== 1) begin miscompares++; $display("FAIL basic.rises got %0d want 1", r); end
        vectors++; if (nqe !== 0) begin miscompares++; $display("FAIL basic.nq_complement got %0d bad want 0", nqe); end
    endtask

    task automatic test_alt_paths();
        int lat, w, nd, r, nqe;
        logic df, tmo;
        nA_in = 1'b0; B_in = 1'b0; nR_in = 1'b1; pulse_len = 16'd5;
        repeat (4) @(negedge clk);
        fire(1, 0, 0, -1, lat, w, nd, df, r, nqe, tmo);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL b_rise.latency got %0d want 3", lat); end
        vectors++; if (w !== 5) begin miscompares++; $display("FAIL b_rise.width got %0d want 5", w); end
        vectors++; if (nd !== 1 || df !== 1'b1) begin miscompares++; $display("FAIL b_rise.done got %0d/%b want 1/1", nd, df); end
        nR_in = 1'b0; nA_in = 1'b0; B_in = 1'b1;
        repeat (4) @(negedge clk);
        fire(2, 0, 0, -1, lat, w, nd, df, r, nqe, tmo);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL nr_rise.latency got %0d want 3", lat); end
        vectors++; if (w !== 5) begin miscompares++; $display("FAIL nr_rise.width got %0d want 5", w); end
        vectors++; if (nd !== 1 || r !== 1) begin miscompares++; $display("FAIL nr_rise.done_rises got %0d/%0d want 1/1", nd, r); end
    endtask

    task automatic test_retrigger();
        int lat, w, nd, r, nqe, exp_w;
        logic df, tmo;
        nA_in = 1'b1; B_in = 1'b1; nR_in = 1'b1; pulse_len = 16'd10;
        repeat (4) @(negedge clk);
        fire(0, 2, 0, -1, lat, w, nd, df, r, nqe, tmo);
        exp_w = RETRIG ? 14 : 10;
        vectors++; if (w !== exp_w) begin miscompares++; $display("FAIL retrig.width got %0d want %0d", w, exp_w); end
        vectors++; if (nd !== 1) begin miscompares++; $display("FAIL retrig.done_count got %0d want 1", nd); end
        vectors++; if (r !== 1) begin miscompares++; $display("FAIL retrig.rises got %0d want 1", r); end
    endtask

    task automatic test_clear();
        int lat, w, nd, r, nqe, highs;
        logic df, tmo;
        nA_in = 1'b1; B_in = 1'b1; nR_in = 1'b1; pulse_len = 16'd100;
        repeat (4) @(negedge clk);
        fire(0, 0, 20, -1, lat, w, nd, df, r, nqe, tmo);
        vectors++; if (w !== 22) begin miscompares++; $display("FAIL clear.width got %0d want 22", w); end
        vectors++; if (nd !== 0) begin miscompares++; $display("FAIL clear.done_count got %0d want 0", nd); end
        vectors++; if (r !== 1) begin miscompares++; $display("FAIL clear.rises got %0d want 1", r); end
        nR_in = 1'b1;
        highs = 0;
        repeat (6) begin
            @(negedge clk);
            if (Q !== 1'b0) highs++;
        end
        vectors++; if (highs !== 0) begin miscompares++; $display("FAIL clear.no_new_pulse got %0d high want 0", highs); end
    endtask

    task automatic test_boundaries();
        int lat, w, nd, r, nqe, exp_w;
        logic df, tmo;
        nA_in = 1'b1; B_in = 1'b1; nR_in = 1'b1; pulse_len = 16'd0;
        repeat (4) @(negedge clk);
        fire(0, 0, 0, -1, lat, w, nd, df, r, nqe, tmo);
        vectors++; if (w !== 1) begin miscompares++; $display("FAIL len0.width got %0d want 1", w); end
        vectors++; if (nd !== 1 || df !== 1'b1) begin miscompares++; $display("FAIL len0.done got %0d/%b want 1/1", nd, df); end
        pulse_len = 16'hFFFF;
        repeat (4) @(negedge clk);
        fire(0, 0, 0, -1, lat, w, nd, df, r, nqe, tmo);
        vectors++; if (tmo !== 1'b0) begin miscompares++; $display("FAIL lenmax.timeout got %b want 0", tmo); end
        vectors++; if (w !== 65535) begin miscompares++; $display("FAIL lenmax.width got %0d want 65535", w); end
        vectors++; if (nd !== 1) begin miscompares++; $display("FAIL lenmax.done_count got %0d want 1", nd); end
        pulse_len = 16'd5;
        repeat (4) @(negedge clk);
        fire(0, 3, 0, -1, lat, w, nd, df, r, nqe, tmo);
        exp_w = RETRIG ? 10 : 5;
        vectors++; if (w !== exp_w) begin miscompares++; $display("FAIL coincide.width got %0d want %0d", w, exp_w); end
        vectors++; if (nd !== 1 || df !== 1'b1) begin miscompares++; $display("FAIL coincide.done got %0d/%b want 1/1", nd, df); end
        vectors++; if (r !== 1) begin miscompares++; $display("FAIL coincide.rises got %0d want 1", r); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alt_paths();
        test_retrigger();
        test_clear();
        test_boundaries();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
